pixel_fb_writer: RTL and testbench

//  Sink end of the line-drawer pixel stream (draw, x, y). Queues pixels in a small FIFO and

---
 rtl/pong_pkg.sv | 22 ++
 rtl/pixel_fifo.sv | 55 +++++
 rtl/pixel_fb_writer.sv | 143 ++++++++++++++
 tb/tb_pixel_fb_writer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants and types for the pong video path: framebuffer geometry,
// the queued pixel record and the framebuffer writer state encoding.
package pong_pkg;

  localparam int FB_SCREEN_W   = 320;
  localparam int FB_SCREEN_H   = 240;
  localparam int FB_COLOR_W    = 3;
  localparam int FB_ADDR_W     = 17;
  localparam int FB_FIFO_DEPTH = 8;

  typedef struct packed {
    logic [FB_ADDR_W-1:0]  addr;
    logic [FB_COLOR_W-1:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR
  } fb_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO with the head entry visible combinationally, so the
// consumer can present it on the same cycle it becomes valid.
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push, do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/pixel_fb_writer.sv
// Pixel stream sink: queues drawn pixels and writes them into the framebuffer
// over a valid/ready port, and runs full-screen clear sweeps on request.
module pixel_fb_writer
  import pong_pkg::*;
#(
  parameter int SCREEN_W   = FB_SCREEN_W,
  parameter int SCREEN_H   = FB_SCREEN_H,
  parameter int COLOR_W    = FB_COLOR_W,
  parameter int FIFO_DEPTH = FB_FIFO_DEPTH,
  parameter int ADDR_W     = FB_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               draw,
  input  logic [8:0]         x_in,
  input  logic [7:0]         y_in,
  input  logic [COLOR_W-1:0] colour_in,
  output logic               full,
  output logic               overflow,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_colour,
  output logic               clear_done,
  output logic               busy,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  input  logic               mem_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  fb_state_t          state_reg, state_next;
  logic               pending_reg, pending_next;
  logic               overflow_reg;
  logic [COLOR_W-1:0] clear_colour_reg;
  logic [ADDR_W-1:0]  sweep_reg, sweep_next;

  logic               in_range, push, pop, clear_accept, last_pop;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  pixel_t             push_pixel, head_pixel;

  assign in_range          = (int'(x_in) < SCREEN_W) && (int'(y_in) < SCREEN_H);
  assign push              = draw && in_range && !fifo_full;
  assign push_pixel.addr   = ADDR_W'(y_in) * ADDR_W'(SCREEN_W) + ADDR_W'(x_in);
  assign push_pixel.colour = colour_in;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pixel_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_pixel),
    .head  (head_pixel),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A request is only taken when no clear is already pending or running.
  assign clear_accept = clear_start && !pending_reg && (state_reg != CLEAR);
  // True when the pop in progress leaves the FIFO empty (a same-cycle push refills it).
  assign last_pop     = (fifo_count == CNT_W'(1)) && !push;

  assign full     = fifo_full;
  assign overflow = overflow_reg;
  assign busy     = (state_reg != IDLE) || pending_reg || !fifo_empty;

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg | clear_accept;
    sweep_next   = sweep_reg;
    pop          = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_data     = '0;
    clear_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending_reg && fifo_empty) begin
          state_next   = CLEAR;
          pending_next = 1'b0;
          sweep_next   = '0;
        end else if (!fifo_empty || push) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        mem_we   = 1'b1;
        mem_addr = head_pixel.addr;
        mem_data = head_pixel.colour;
        if (mem_ready) begin
          pop = 1'b1;
          if (pending_reg && last_pop) begin
            state_next   = CLEAR;
            pending_next = 1'b0;
            sweep_next   = '0;
          end else if (last_pop) begin
            state_next = IDLE;
          end
        end
      end
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = sweep_reg;
        mem_data = clear_colour_reg;
        if (mem_ready) begin
          if (sweep_reg == LAST_ADDR) begin
            clear_done = 1'b1;
            state_next = IDLE;
            sweep_next = '0;
          end else begin
            sweep_next = sweep_reg + ADDR_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      pending_reg      <= 1'b0;
      overflow_reg     <= 1'b0;
      sweep_reg        <= '0;
      clear_colour_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      sweep_reg    <= sweep_next;
      overflow_reg <= overflow_reg | (draw && in_range && fifo_full);
      if (clear_accept) begin
        clear_colour_reg <= clear_colour;
      end
    end
  end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Bench for pixel_fb_writer: vector table, randomized traffic against an
// expected-write queue, and hand-written overflow / clear / reset sequences.
module tb_pixel_fb_writer;

  localparam int W    = 320;
  localparam int H    = 240;
  localparam int LAST = W * H - 1;

  logic        clk;
  logic        reset;
  logic        draw;
  logic [8:0]  x_in;
  logic [7:0]  y_in;
  logic [2:0]  colour_in;
  logic        full;
  logic        overflow;
  logic        clear_start;
  logic [2:0]  clear_colour;
  logic        clear_done;
  logic        busy;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_ready;

  pixel_fb_writer dut (
    .clk          (clk),
    .reset        (reset),
    .draw         (draw),
    .x_in         (x_in),
    .y_in         (y_in),
    .colour_in    (colour_in),
    .full         (full),
    .overflow     (overflow),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .clear_done   (clear_done),
    .busy         (busy),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Reference model: the ordered list of writes the framebuffer should see.
  typedef struct {
    logic [16:0] addr;
    logic [2:0]  data;
    logic        done;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  task automatic push_exp(input int a, input int d, input bit done);
    wr_t e;
    e.addr = 17'(a);
    e.data = 3'(d);
    e.done = done;
    exp_q.push_back(e);
  endtask

  function automatic bit on_screen(input int x, input int y);
    return (x < W) && (y < H);
  endfunction

  task automatic exp_sweep(input int c);
    for (int a = 0; a <= LAST; a++) push_exp(a, c, a == LAST);
  endtask

  // Write monitor: sampled at negedge, so the values seen are what the next posedge commits.
  logic        stall_prev = 1'b0;
  logic [16:0] addr_prev;
  logic [2:0]  data_prev;
  int          done_count = 0;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_we", mem_we, 1);
        check("hold_addr", mem_addr, addr_prev);
        check("hold_data", mem_data, data_prev);
      end
      if (mem_we && mem_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", mem_addr, mem_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", mem_addr, mon_e.addr);
          check("wr_data", mem_data, mon_e.data);
          check("wr_clear_done", clear_done, mon_e.done);
        end
        if (clear_done) done_count++;
      end else begin
        check("clear_done_idle", clear_done, 0);
      end
      stall_prev = mem_we && !mem_ready;
      addr_prev  = mem_addr;
      data_prev  = mem_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_busy"}, busy, 0);
  endtask

  task automatic do_draw(input int x, input int y, input int c);
    draw      = 1'b1;
    x_in      = 9'(x);
    y_in      = 8'(y);
    colour_in = 3'(c);
  endtask

  typedef struct {
    int x;
    int y;
    int c;
    bit acc;
    int addr;
  } vec_t;

  vec_t vecs[8];
  int   done_before;

  initial begin
    vecs[0] = '{5,   2,   3, 1, 645};
    vecs[1] = '{320, 0,   1, 0, 0};
    vecs[2] = '{0,   240, 2, 0, 0};
    vecs[3] = '{0,   0,   7, 1, 0};
    vecs[4] = '{319, 239, 6, 1, 76799};
    vecs[5] = '{319, 0,   5, 1, 319};
    vecs[6] = '{0,   239, 4, 1, 76480};
    vecs[7] = '{511, 255, 1, 0, 0};

    reset = 1'b1; draw = 1'b0; x_in = '0; y_in = '0; colour_in = '0;
    clear_start = 1'b0; clear_colour = '0; mem_ready = 1'b1;
    repeat (3) step();
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    reset = 1'b0;
    step();

    // Single draws: latency, address and range checks.
    foreach (vecs[i]) begin
      do_draw(vecs[i].x, vecs[i].y, vecs[i].c);
      if (vecs[i].acc) push_exp(vecs[i].addr, vecs[i].c, 0);
      step();
      draw = 1'b0;
      check("vec_we", mem_we, vecs[i].acc);
      check("vec_addr", mem_addr, vecs[i].acc ? vecs[i].addr : 0);
      check("vec_data", mem_data, vecs[i].acc ? vecs[i].c : 0);
      step();
      check("vec_busy_n2", busy, 0);
      check("vec_we_n2", mem_we, 0);
      step();
    end
    check("vec_overflow", overflow, 0);

    // Random traffic with random stalls; upstream honours full.
    for (int i = 0; i < 1500; i++) begin
      int x, y, c;
      mem_ready = ($urandom_range(0, 3) != 0);
      if (!full && $urandom_range(0, 1) == 1) begin
        x = $urandom_range(0, 339);
        y = $urandom_range(0, 249);
        c = $urandom_range(0, 7);
        do_draw(x, y, c);
        if (on_screen(x, y)) push_exp(y * W + x, c, 0);
      end else begin
        draw = 1'b0;
      end
      step();
    end
    draw = 1'b0;
    mem_ready = 1'b1;
    drain("rand_drain", 200);
    check("rand_overflow", overflow, 0);

    // Overflow: 10 back-to-back draws into a stalled writer.
    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_draw(i, 5, i);
      if (i < 8) push_exp(5 * W + i, i, 0);
      step();
      check("ovf_full", full, i >= 7);
      check("ovf_flag", overflow, i >= 8);
    end
    draw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("ovf_stall_addr", mem_addr, 5 * W);
      check("ovf_stall_busy", busy, 1);
      step();
    end
    mem_ready = 1'b1;
    drain("ovf_drain", 50);
    check("ovf_sticky", overflow, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("ovf_reset", overflow, 0);
    step();

    // Two queued pixels, full-screen clear, second request ignored, draw mid-sweep.
    mem_ready = 1'b0;
    do_draw(10, 20, 1); push_exp(20 * W + 10, 1, 0); step();
    do_draw(300, 200, 6); push_exp(200 * W + 300, 6, 0); step();
    draw = 1'b0;
    clear_start = 1'b1; clear_colour = 3'd5; exp_sweep(5); step();
    clear_start = 1'b0; clear_colour = 3'd0;
    repeat (3) step();
    mem_ready = 1'b1;
    done_before = done_count;
    repeat (100) step();
    clear_start = 1'b1; clear_colour = 3'd7; step();
    clear_start = 1'b0;
    do_draw(1, 1, 2); push_exp(321, 2, 0); step();
    draw = 1'b0;
    drain("clear_drain", 80000);
    check("clear_done_count", done_count - done_before, 1);

    // Reset in the middle of a sweep with pixels queued.
    clear_start = 1'b1; clear_colour = 3'd6; exp_sweep(6); step();
    clear_start = 1'b0;
    repeat (20) step();
    do_draw(50, 50, 3); step();
    do_draw(60, 60, 4); step();
    draw = 1'b0;
    repeat (10) step();
    done_before = done_count;
    reset = 1'b1;
    exp_q.delete();
    step();
    check("rst6_we", mem_we, 0);
    check("rst6_busy", busy, 0);
    check("rst6_clear_done", clear_done, 0);
    check("rst6_full", full, 0);
    reset = 1'b0;
    step();
    do_draw(7, 3, 4); push_exp(967, 4, 0); step();
    draw = 1'b0;
    check("rst6_new_we", mem_we, 1);
    check("rst6_new_addr", mem_addr, 967);
    drain("rst6_drain", 50);
    check("rst6_no_done", done_count - done_before, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
